atm_session_ctrl: RTL

- Session sequencer for the ATM card/balance datapath.
- Tracks card insertion and the password strobe, and samples the datapath's wrong_psw flag.
- Enforces a retry limit and an inactivity timeout.
- Executes balance, deposit and withdraw operations, then drives updated_balance/op_done back into the card-handling datapath.
- Sits between the user-facing front panel and the card/balance store.

---
 rtl/atm_pkg.sv | 25 ++
 rtl/atm_balance_alu.sv | 39 +++
 rtl/atm_session_ctrl.sv | 183 ++++++++++++++++++
 3 files changed

// File: rtl/atm_pkg.sv
// Shared definitions for the ATM session sequencer: FSM states, operation
// codes and error codes used by atm_session_ctrl and atm_balance_alu.
package atm_pkg;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    WAIT_PSW = 3'd1,
    CHECK    = 3'd2,
    MENU     = 3'd3,
    EXEC     = 3'd4,
    DONE     = 3'd5,
    EJECT    = 3'd6
  } state_t;

  localparam logic [1:0] OP_INQ = 2'b00;
  localparam logic [1:0] OP_DEP = 2'b01;
  localparam logic [1:0] OP_WDR = 2'b10;
  localparam logic [1:0] OP_END = 2'b11;

  localparam logic [1:0] ERR_NONE = 2'b00;
  localparam logic [1:0] ERR_NSF  = 2'b01;
  localparam logic [1:0] ERR_OVF  = 2'b10;
  localparam logic [1:0] ERR_TMO  = 2'b11;

endpackage

// File: rtl/atm_balance_alu.sv
// Combinational balance arithmetic for one session operation.
// Ports:
//   op_code    - operation (inquiry / deposit / withdraw / end)
//   value      - current working balance
//   amount     - operation amount
//   next_value - resulting balance (unchanged on error)
//   err        - ERR_NONE, ERR_NSF (insufficient funds) or ERR_OVF (overflow)
module atm_balance_alu
  import atm_pkg::*;
#(
  parameter int unsigned balance_width = 20
) (
  input  logic [1:0]               op_code,
  input  logic [balance_width-1:0] value,
  input  logic [balance_width-1:0] amount,
  output logic [balance_width-1:0] next_value,
  output logic [1:0]               err
);

  logic [balance_width:0] sum;

  always_comb begin
    sum        = {1'b0, value} + {1'b0, amount};
    next_value = value;
    err        = ERR_NONE;
    case (op_code)
      OP_DEP: begin
        if (sum[balance_width]) err = ERR_OVF;
        else                    next_value = sum[balance_width-1:0];
      end
      OP_WDR: begin
        if (amount > value) err = ERR_NSF;
        else                next_value = value - amount;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/atm_session_ctrl.sv
// ATM session sequencer: card insertion, password check with retry limit,
// inactivity timeout, and balance/deposit/withdraw execution.
// Ports:
//   clk, rst         - clock, asynchronous active-low reset
//   card_in          - card present level
//   psw_strobe       - password valid pulse
//   wrong_psw        - datapath mismatch flag, valid one cycle after strobe
//   balance          - current account balance from datapath
//   op_valid/op_code/amount - operation request
//   updated_balance  - balance to commit to datapath
//   op_done          - one-cycle commit pulse
//   authed           - high in MENU/EXEC/DONE
//   card_locked      - one-cycle pulse on retry exhaustion
//   eject            - one-cycle card-eject pulse
//   err              - last error code
//   state_o          - current state for debug
// All outputs are registered; pulses are derived from the next state.
module atm_session_ctrl
  import atm_pkg::*;
#(
  parameter int unsigned balance_width  = 20,
  parameter int unsigned max_tries      = 3,
  parameter int unsigned timeout_cycles = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     card_in,
  input  logic                     psw_strobe,
  input  logic                     wrong_psw,
  input  logic [balance_width-1:0] balance,
  input  logic                     op_valid,
  input  logic [1:0]               op_code,
  input  logic [balance_width-1:0] amount,
  output logic [balance_width-1:0] updated_balance,
  output logic                     op_done,
  output logic                     authed,
  output logic                     card_locked,
  output logic                     eject,
  output logic [1:0]               err,
  output logic [2:0]               state_o
);

  localparam int unsigned TRY_W = $clog2(max_tries + 1);
  localparam int unsigned TMR_W = $clog2(timeout_cycles);
  localparam logic [TRY_W-1:0] TRY_LAST = TRY_W'(max_tries - 1);
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(timeout_cycles - 1);

  state_t                   state, state_n;
  logic [TMR_W-1:0]         timer, timer_n;
  logic [TRY_W-1:0]         tries, tries_n;
  logic [balance_width-1:0] ub_n, amt_q, amt_n, alu_val;
  logic [1:0]               op_q, op_n, err_n, alu_err;
  logic                     done_n, lock_n, eject_n, authed_n;

  atm_balance_alu #(.balance_width(balance_width)) u_alu (
    .op_code   (op_q),
    .value     (updated_balance),
    .amount    (amt_q),
    .next_value(alu_val),
    .err       (alu_err)
  );

  always_comb begin
    state_n = state;
    timer_n = timer;
    tries_n = tries;
    ub_n    = updated_balance;
    err_n   = err;
    op_n    = op_q;
    amt_n   = amt_q;
    lock_n  = 1'b0;
    case (state)
      IDLE: begin
        timer_n = '0;
        err_n   = ERR_NONE;
        if (card_in) state_n = WAIT_PSW;
      end
      WAIT_PSW: begin
        if (psw_strobe) begin
          state_n = CHECK;
          timer_n = '0;
        end else if (timer == TMR_LAST) begin
          state_n = EJECT;
          err_n   = ERR_TMO;
          timer_n = '0;
        end else begin
          timer_n = timer + 1'b1;
        end
      end
      CHECK: begin
        if (!wrong_psw) begin
          state_n = MENU;
          tries_n = '0;
          ub_n    = balance;
        end else if (tries == TRY_LAST) begin
          lock_n  = 1'b1;
          state_n = EJECT;
        end else begin
          tries_n = tries + 1'b1;
          state_n = WAIT_PSW;
        end
      end
      MENU: begin
        if (op_valid) begin
          err_n   = ERR_NONE;
          timer_n = '0;
          if (op_code == OP_END) begin
            state_n = EJECT;
          end else begin
            state_n = EXEC;
            op_n    = op_code;
            amt_n   = amount;
          end
        end else if (timer == TMR_LAST) begin
          state_n = EJECT;
          err_n   = ERR_TMO;
          timer_n = '0;
        end else begin
          timer_n = timer + 1'b1;
        end
      end
      EXEC: begin
        ub_n    = alu_val;
        err_n   = alu_err;
        state_n = DONE;
      end
      DONE: begin
        state_n = MENU;
        timer_n = '0;
      end
      EJECT: begin
        state_n = IDLE;
        tries_n = '0;
      end
      default: state_n = IDLE;
    endcase

    // Card removal overrides every transition above: no commit, no pulses.
    if (state != IDLE && !card_in) begin
      state_n = IDLE;
      tries_n = '0;
      timer_n = '0;
      lock_n  = 1'b0;
      ub_n    = updated_balance;
      err_n   = err;
    end

    done_n   = (state_n == DONE);
    eject_n  = (state_n == EJECT);
    authed_n = (state_n inside {MENU, EXEC, DONE});
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state           <= IDLE;
      timer           <= '0;
      tries           <= '0;
      updated_balance <= '0;
      err             <= ERR_NONE;
      op_q            <= OP_INQ;
      amt_q           <= '0;
      op_done         <= 1'b0;
      authed          <= 1'b0;
      card_locked     <= 1'b0;
      eject           <= 1'b0;
    end else begin
      state           <= state_n;
      timer           <= timer_n;
      tries           <= tries_n;
      updated_balance <= ub_n;
      err             <= err_n;
      op_q            <= op_n;
      amt_q           <= amt_n;
      op_done         <= done_n;
      authed          <= authed_n;
      card_locked     <= lock_n;
      eject           <= eject_n;
    end
  end

  assign state_o = state;

endmodule
